spi_reg_peripheral: RTL
=======================

# spi_reg_peripheral

SPI responder (mode 0, MSB first) that exposes a small register file to an external SPI initiator: the MicroBlaze SPI master, or an off-board host. It sits beside the video card logic in the `Clk` domain. Its outputs are:
- a flat register bus;
- a one-cycle write strobe, so downstream blocks (palette, scroll, mode registers) can be configured over SPI without going through GPIO.

## Interface
Parameters:
- `NREGS`, 16: register count; power of 2, from 2 to 128. The address width is `AW = $clog2(NREGS)`.
- `ID_VALUE`, 8'hA5: read-only contents of register 0.

Ports:
- `Clk`  in  1  system clock (100 MHz).
- `reset_rtl_0`  in  1  reset; one clock, reset is asynchronous and active-low.
- `spi_sclk`  in  1  SPI clock from the initiator; asynchronous to `Clk`.
- `spi_ss_n`  in  1  slave select, active low; asynchronous.
- `spi_mosi`  in  1  initiator data in; asynchronous.
- `spi_miso`  out  1  responder data out.
- `spi_miso_oe`  out  1  tristate enable for `spi_miso`; high only while selected.
- `reg_o`  out  NREGS*8  flat register contents; register n occupies bits [8n+7:8n].
- `wr_strobe`  out  1  one-`Clk` pulse per completed write byte.
- `wr_addr`  out  AW  address of the write flagged by `wr_strobe`.
- `wr_data`  out  8  data of the write flagged by `wr_strobe`.

## Operation
Input conditioning:
- `spi_sclk`, `spi_ss_n` and `spi_mosi` each pass through a 2-flop synchronizer.
- Rising and falling edges of SCLK are detected from the synchronized value plus one extra delay flop.

Frame format:
- A frame is everything between `ss_n` falling and `ss_n` rising.
- Byte 0 is the command: bit 7 = 1 for read, 0 for write. Bits [AW-1:0] are the address; bits 6:AW are ignored.
- Bytes 1 and onward are data bytes, in burst mode. The address auto-increments after every data byte and wraps from NREGS-1 to 0.

State machine: IDLE, CMD, DATA.
- IDLE -> CMD on synchronized `ss_n` low. The bit counter is cleared.
- CMD: MOSI is sampled on each SCLK rising edge. After the 8th bit, latch rw and address, then go to DATA. The bit counter restarts.
- DATA, write: after the 8th rising edge, store the byte to `reg[addr]` unless addr == 0. Pulse `wr_strobe` in either case; `wr_addr`/`wr_data` carry the byte even when addr == 0.
- DATA, read: on entry and after each byte, load the shift register with `reg[addr]` (or `ID_VALUE` when addr == 0). `spi_miso` = shift[7] at once; shift left on each SCLK falling edge.
- Any state -> IDLE when synchronized `ss_n` goes high. A partial byte is discarded and nothing is written.

Output behaviour:
- `spi_miso` = 0 in IDLE and CMD and during write frames.
- `spi_miso_oe` = ~synchronized `ss_n`.
- Register 0 always reads `ID_VALUE`, and its slot in `reg_o` holds `ID_VALUE`.
- A write byte and a frame end never coincide in the same `Clk` cycle: the 8th rising edge is processed before `ss_n` deasserts. If they do coincide after synchronization, the write completes first.

## Timing
- Reset values: all registers 0 (register 0 reads `ID_VALUE`); `spi_miso` 0; `spi_miso_oe` 0; `wr_strobe` 0; `wr_addr` 0; `wr_data` 0; state IDLE; counters 0.
- SCLK edge to internal action: 3 `Clk` cycles (2 synchronizer stages plus the edge register).
- `wr_strobe` is asserted on the cycle after the 8th-bit edge is detected. `reg_o` updates in the same cycle as `wr_strobe`.
- Read data: the first MISO bit is valid no more than 4 `Clk` cycles after the 8th command rising edge is detected.
- Requirements on the initiator:
  - SCLK frequency at most `Clk`/8; each SCLK half-period at least 4 `Clk` cycles.
  - `ss_n` setup before the first edge, and hold after the last edge, of at least 4 `Clk` cycles.
- Reset asserted mid-frame: immediate return to the reset values. Bits already shifted in are lost.

## Configuration
- `SPI_PERIPH_IRQ_EN` defined:
  - Adds output `irq_o`, 1 bit, reset value 0.
  - `irq_o` is set on every `wr_strobe`.
  - It is cleared when a read frame addresses register 0; the clear happens when the command byte completes.
  - If a set and a clear occur in the same cycle, the set wins.
- Not defined: there is no `irq_o` port and no IRQ logic.

## Structure
- Package `spi_periph_pkg` holds:
  - the state enum `spi_state_t` (IDLE, CMD, DATA);
  - the constant `CMD_RD_BIT = 7`;
  - the constant `SYNC_STAGES = 2`.
- Sub-module `spi_sync_edge`: a 2-flop synchronizer with rise/fall detect, instantiated once per input (rise/fall detect needed for SCLK only). Uses the same async active-low reset.

## Test plan
- Reset check: assert `reset_rtl_0` = 0 -> all outputs 0 and `reg_o` register 0 slot = 8'hA5. Deassert reset, then read addr 0 -> MISO returns 8'hA5.
- Single write: SCLK = `Clk`/8, write frame 0x03, 0x5C -> `wr_strobe` pulses once with `wr_addr` = 3 and `wr_data` = 0x5C; `reg_o[31:24]` = 0x5C. Then read addr 3 -> 0x5C.
- Burst with wrap: write frame addr 14 with data 0x11, 0x22, 0x33 -> reg14 = 0x11, reg15 = 0x22; reg0 unchanged (still reads 0xA5); 3 strobes, the third with `wr_addr` = 0.
- Aborted frame: write command for addr 5, 4 data bits, then `ss_n` high -> no `wr_strobe`, reg5 unchanged. The next full frame works normally.
- Mid-frame reset: drop reset during the data byte of a read -> `spi_miso_oe` and `spi_miso` go to 0 immediately, and all registers clear.
- With `SPI_PERIPH_IRQ_EN` defined: write to addr 2 -> `irq_o` = 1. Read addr 0 -> `irq_o` = 0 after the command byte. A write then sets it again.

Source files
------------

// File: rtl/spi_reg_peripheral_pkg.sv
// Shared types and constants for the SPI register peripheral.
package spi_periph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // Command byte bit that selects read (1) or write (0)
    localparam int CMD_RD_BIT  = 7;
    // Flops in each input synchronizer
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an initiator (master) and the register peripheral (slave).
interface spi_reg_peripheral_if;
    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk, spi_ss_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Synchronizer for one asynchronous SPI pin, plus a delay flop for edge detect.
// RST_VAL sets the idle level the chain holds through reset.
module spi_sync_edge
    import spi_periph_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   q_d;

    // Synchronizer chain and one extra stage for edge comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            q_d  <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 responder exposing an NREGS x 8 register file.
// Frame: command byte {rw, ignored, addr}, then burst data bytes with
// auto-incrementing, wrapping address. Register 0 is a read-only ID.
// Optional macro SPI_PERIPH_IRQ_EN adds irq_o (set on write, cleared by
// a read command addressing register 0).
module spi_reg_peripheral
    import spi_periph_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    localparam int         AW       = $clog2(NREGS)
) (
    input  logic                 Clk,
    input  logic                 reset_rtl_0,
    spi_reg_peripheral_if.slave  spi,
    output logic [NREGS*8-1:0]   reg_o,
    output logic                 wr_strobe,
    output logic [AW-1:0]        wr_addr,
    output logic [7:0]           wr_data
`ifdef SPI_PERIPH_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(Clk), .rst_n(reset_rtl_0), .d(spi.spi_sclk),
                                            .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss   (.clk(Clk), .rst_n(reset_rtl_0), .d(spi.spi_ss_n),
                                            .q(ss_q), .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(Clk), .rst_n(reset_rtl_0), .d(spi.spi_mosi),
                                            .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

    // Edge outputs of the level-only inputs are intentionally left unused
    logic unused_edges;
    assign unused_edges = ^{sclk_q, ss_rise, ss_fall, mosi_rise, mosi_fall};

    spi_state_t               state_q, state_d;
    logic [2:0]               bit_cnt;
    logic [6:0]               shift_in;
    logic [7:0]               shift_out;
    logic                     rw;
    logic [AW-1:0]            addr;
    logic [NREGS-1:0][7:0]    regs;   // regs[0] is held at ID_VALUE

    logic [7:0]    byte_in;
    logic          byte_done, cmd_done, wr_fire, rd_next;
    logic [AW-1:0] cmd_addr;

    assign byte_in   = {shift_in, mosi_q};
    assign cmd_addr  = byte_in[AW-1:0];
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign cmd_done  = (state_q == CMD) && byte_done;
    // A completing write byte is honoured even if ss_n rises in the same cycle
    assign wr_fire   = (state_q == DATA) && !rw && byte_done;
    assign rd_next   = (state_q == DATA) &&  rw && byte_done;

    // State register
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!ss_q) state_d = CMD;
            CMD:     if (ss_q) state_d = IDLE;
                     else if (byte_done) state_d = DATA;
            DATA:    if (ss_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifting, command latch, register writes and read data loading
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            regs      <= '0;
            regs[0]   <= ID_VALUE;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_in <= byte_in[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (cmd_done) begin
                rw        <= byte_in[CMD_RD_BIT];
                addr      <= cmd_addr;
                shift_out <= regs[cmd_addr];
            end
            if (wr_fire) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= byte_in;
                if (addr != '0) regs[addr] <= byte_in;
                addr      <= addr + 1'b1;
            end
            if (rd_next) begin
                addr      <= addr + 1'b1;
                shift_out <= regs[addr + 1'b1];
            end else if ((state_q == DATA) && rw && sclk_fall && (bit_cnt != 3'd0)) begin
                // The falling edge right after a load (bit_cnt == 0) must not
                // shift, or the MSB would never reach the initiator.
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_PERIPH_IRQ_EN
    // Write sets the flag; a read command to register 0 clears it; set wins
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0)                                            irq_o <= 1'b0;
        else if (wr_fire)                                            irq_o <= 1'b1;
        else if (cmd_done && byte_in[CMD_RD_BIT] && cmd_addr == '0)  irq_o <= 1'b0;
    end
`endif

    assign spi.spi_miso    = ((state_q == DATA) && rw) ? shift_out[7] : 1'b0;
    assign spi.spi_miso_oe = ~ss_q;
    assign reg_o           = regs;

endmodule
